sub_bytes_iter: RTL and testbench

//   Sequential AES SubBytes engine, the forward (encrypt) counterpart of the inverse byte-substitution stage.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/sub_bytes_iter_sbox.sv | 21 ++
 rtl/sub_bytes_iter.sv | 138 +++++++++++++
 tb/tb_sub_bytes_iter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) S-box helper functions.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] e;
    r = 8'h01;
    b = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        r = gf_mul(r, b);
      end else begin
        r = r;
      end
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  // Rotate a byte left by n bits.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: undo the affine transform, then invert.
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] t;
    t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/sub_bytes_iter_sbox.sv
// Single-byte AES substitution boxes used by the lane array of sub_bytes_iter.
// The inverse box only exists when SUB_BYTES_INV_MODE_EN is defined.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] result
);
  assign result = sbox_fwd(data);
endmodule

`ifdef SUB_BYTES_INV_MODE_EN
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] result
);
  assign result = sbox_inv(data);
endmodule
`endif

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: substitutes LANES bytes of a 128-bit state
// per cycle (least significant lane first) and holds the result under
// valid/ready handshakes on both sides.
// Optional feature macro: SUB_BYTES_INV_MODE_EN adds an inv_mode input that
// selects the inverse S-box for the whole state, captured on accept.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] w0_curr,
  input  logic [AES_WORD_W-1:0] w1_curr,
  input  logic [AES_WORD_W-1:0] w2_curr,
  input  logic [AES_WORD_W-1:0] w3_curr,
`ifdef SUB_BYTES_INV_MODE_EN
  input  logic                  inv_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] w0_next,
  output logic [AES_WORD_W-1:0] w1_next,
  output logic [AES_WORD_W-1:0] w2_next,
  output logic [AES_WORD_W-1:0] w3_next,
  output logic                  busy
);

  localparam int unsigned BEATS   = AES_BYTES / LANES;
  localparam int unsigned CNT_W   = $clog2(BEATS) + 1;
  localparam int unsigned CHUNK_W = 8 * LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_state_e             state_r;
  fsm_state_e             state_s;
  logic [AES_STATE_W-1:0] st_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CHUNK_W-1:0]     chunk_s;
  logic [CHUNK_W-1:0]     sub_s;
  logic                   accept_s;
  logic                   last_beat_s;
`ifdef SUB_BYTES_INV_MODE_EN
  logic                   inv_mode_r;
`endif

  assign in_ready    = (state_r == IDLE) && !rst;
  assign accept_s    = in_valid && in_ready;
  assign last_beat_s = (cnt_r == CNT_W'(BEATS - 1));
  assign out_valid   = (state_r == DONE);
  assign busy        = (state_r != IDLE);

  // Outputs come straight from the state register, never from the inputs.
  assign w0_next = st_r[127:96];
  assign w1_next = st_r[95:64];
  assign w2_next = st_r[63:32];
  assign w3_next = st_r[31:0];

  // Select the group of bytes being substituted on this beat.
  always_comb begin
    chunk_s = st_r[CHUNK_W*cnt_r +: CHUNK_W];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] fwd_s;
    aes_sbox u_sbox (
      .data   (chunk_s[8*i +: 8]),
      .result (fwd_s)
    );
`ifdef SUB_BYTES_INV_MODE_EN
    logic [7:0] inv_s;
    aes_inv_sbox u_inv_sbox (
      .data   (chunk_s[8*i +: 8]),
      .result (inv_s)
    );
    assign sub_s[8*i +: 8] = inv_mode_r ? inv_s : fwd_s;
`else
    assign sub_s[8*i +: 8] = fwd_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: accept only in IDLE, fixed beat count, hold DONE until taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_beat_s) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: load on accept, substitute one lane group per RUN cycle, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r  <= {AES_STATE_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
`ifdef SUB_BYTES_INV_MODE_EN
      inv_mode_r <= 1'b0;
`endif
    end else if (accept_s) begin
      st_r  <= {w0_curr, w1_curr, w2_curr, w3_curr};
      cnt_r <= {CNT_W{1'b0}};
`ifdef SUB_BYTES_INV_MODE_EN
      inv_mode_r <= inv_mode;
`endif
    end else if (state_r == RUN) begin
      st_r[CHUNK_W*cnt_r +: CHUNK_W] <= sub_s;
      cnt_r <= cnt_r + 1'b1;
    end else begin
      st_r  <= st_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter. The reference S-box tables are built
// with the classic generator walk (powers of 3), independent of the RTL's
// inverse-plus-affine functions; outputs are checked every cycle against a
// transaction-level model. Extra instances cover LANES = 1, 2, 8, 16.
`timescale 1ns/1ps
module tb_sub_bytes_iter;

  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = 16 / LANES;
  localparam logic [127:0] KNOWN     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KNOWN_RES = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state;
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;
  logic         inv_sel;
`ifdef SUB_BYTES_INV_MODE_EN
  logic         inv_mode;
  assign inv_sel = inv_mode;
`else
  assign inv_sel = 1'b0;
`endif

  sub_bytes_iter #(.LANES(LANES)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w0_curr   (in_state[127:96]),
    .w1_curr   (in_state[95:64]),
    .w2_curr   (in_state[63:32]),
    .w3_curr   (in_state[31:0]),
`ifdef SUB_BYTES_INV_MODE_EN
    .inv_mode  (inv_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w0_next   (w0_next),
    .w1_next   (w1_next),
    .w2_next   (w2_next),
    .w3_next   (w3_next),
    .busy      (busy)
  );

  // Additional instances with the other legal lane counts.
  logic [3:0]        x_valid, x_ready, x_ovalid, x_busy;
  logic [127:0]      x_state;
  logic [3:0][127:0] x_out;

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_x
    localparam int unsigned XLANES = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    logic [31:0] a, b, c, d;
    sub_bytes_iter #(.LANES(XLANES)) u_x (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (x_valid[g]),
      .in_ready  (x_ready[g]),
      .w0_curr   (x_state[127:96]),
      .w1_curr   (x_state[95:64]),
      .w2_curr   (x_state[63:32]),
      .w3_curr   (x_state[31:0]),
`ifdef SUB_BYTES_INV_MODE_EN
      .inv_mode  (1'b0),
`endif
      .out_valid (x_ovalid[g]),
      .out_ready (1'b1),
      .w0_next   (a),
      .w1_next   (b),
      .w2_next   (c),
      .w3_next   (d),
      .busy      (x_busy[g])
    );
    assign x_out[g] = {a, b, c, d};
  end

  // ---------------- reference tables and model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isb[s[8*i +: 8]] : sb[s[8*i +: 8]];
    return r;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Transaction-level model of the main instance.
  bit           m_running = 1'b0, m_done = 1'b0, m_acc = 1'b0;
  int           m_left = 0;
  logic [127:0] m_res = 128'h0;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  bit           chk_en = 1'b0;

  // Model update on each rising edge using the bench-driven inputs.
  always @(posedge clk) begin
    m_acc <= 1'b0;
    if (rst) begin
      if ((m_running || m_done) && exp_q.size() > 0) void'(exp_q.pop_back());
      m_running <= 1'b0;
      m_done    <= 1'b0;
      m_left    <= 0;
      m_res     <= 128'h0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_running) begin
      if (m_left == 1) begin
        m_running <= 1'b0;
        m_done    <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (in_valid) begin
      m_running <= 1'b1;
      m_left    <= BEATS;
      m_res     <= model_sub(in_state, inv_sel);
      m_acc     <= 1'b1;
      exp_q.push_back(model_sub(in_state, inv_sel));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkb("in_ready", in_ready, !m_running && !m_done && !rst);
      checkb("out_valid", out_valid, m_done);
      checkb("busy", busy, m_running || m_done);
      if (!m_running) check128("w_next", {w0_next, w1_next, w2_next, w3_next}, m_res);
      if (out_valid && out_ready) got_q.push_back({w0_next, w1_next, w2_next, w3_next});
    end
  end

  // ---------------- driver helpers ----------------
  int n_sent = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [127:0] v, input logic inv, input bit hold);
    bit ok;
    in_state = v;
    in_valid = 1'b1;
`ifdef SUB_BYTES_INV_MODE_EN
    inv_mode = inv;
`else
    if (inv) $display("inverse mode not built");
`endif
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (m_acc) ok = 1'b1;
    end
    checkb("accept_timeout", ok, 1'b1);
    if (ok) n_sent++;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((m_running || m_done) && n < 200) begin
      tick();
      n++;
    end
    checkb("drain_timeout", n < 200, 1'b1);
  endtask

  task automatic run_vec(input string name, input logic [127:0] v, input logic [127:0] exp);
    int lat;
    out_ready = 1'b1;
    send(v, 1'b0, 1'b0);
    wait_out(lat);
    check_int({name, "_latency"}, lat, BEATS);
    check128(name, {w0_next, w1_next, w2_next, w3_next}, exp);
    tick();
  endtask

  task automatic run_lane(input int k, input logic [127:0] v);
    int lat;
    bit seen;
    checkb($sformatf("lane%0d_ready", lanes_of(k)), x_ready[k], 1'b1);
    x_state    = v;
    x_valid[k] = 1'b1;
    tick();
    x_valid[k] = 1'b0;
    x_state    = {$urandom, $urandom, $urandom, $urandom};
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      lat++;
      if (x_ovalid[k]) seen = 1'b1;
    end
    check_int($sformatf("lane%0d_latency", lanes_of(k)), lat, 16 / lanes_of(k));
    check128($sformatf("lane%0d_data", lanes_of(k)), x_out[k], model_sub(v, 1'b0));
    checkb($sformatf("lane%0d_busy", lanes_of(k)), x_busy[k], 1'b1);
    tick();
    checkb($sformatf("lane%0d_idle", lanes_of(k)), x_busy[k], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] snap, v;
    int lat, gap, guard;
    bit fails_seen;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = 128'h0;
    x_valid = 4'h0; x_state = 128'h0;
`ifdef SUB_BYTES_INV_MODE_EN
    inv_mode = 1'b0;
`endif

    // Pin the reference model with hand-known values.
    check128("model_sb00", {120'h0, sb[8'h00]}, 128'h63);
    check128("model_sb53", {120'h0, sb[8'h53]}, 128'hed);
    check128("model_sb01", {120'h0, sb[8'h01]}, 128'h7c);
    check128("model_known", model_sub(KNOWN, 1'b0), KNOWN_RES);
    check128("model_inv_known", model_sub(KNOWN_RES, 1'b1), KNOWN);

    tick();
    chk_en = 1'b1;
    checkb("rst_in_ready", in_ready, 1'b0);
    checkb("rst_out_valid", out_valid, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    check128("rst_w_next", {w0_next, w1_next, w2_next, w3_next}, 128'h0);
    tick();
    rst = 1'b0;
    #1;
    checkb("post_rst_in_ready", in_ready, 1'b1);

    // Known vector and uniform patterns.
    run_vec("known", KNOWN, KNOWN_RES);
    run_vec("zeros", 128'h0, {16{8'h63}});
    run_vec("all53", {16{8'h53}}, {16{8'hed}});

    // Backpressure in DONE.
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    wait_out(lat);
    check_int("bp_latency", lat, BEATS);
    snap = {w0_next, w1_next, w2_next, w3_next};
    for (int i = 0; i < 20; i++) begin
      tick();
      checkb("bp_out_valid", out_valid, 1'b1);
      checkb("bp_in_ready", in_ready, 1'b0);
      check128("bp_hold", {w0_next, w1_next, w2_next, w3_next}, snap);
    end
    out_ready = 1'b1;
    tick();
    checkb("bp_release_valid", out_valid, 1'b0);
    checkb("bp_release_ready", in_ready, 1'b1);

    // Reset in the middle of RUN at beat 2.
    send(KNOWN, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkb("midrst_in_ready", in_ready, 1'b1);
    fails_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) fails_seen = 1'b1;
    end
    checkb("midrst_no_output", fails_seen, 1'b0);
    run_vec("after_rst", {16{8'h53}}, {16{8'hed}});

    // Back-to-back with in_valid held high.
    send(KNOWN, 1'b0, 1'b1);
    send(128'h0, 1'b0, 1'b1);
    send({16{8'h53}}, 1'b0, 1'b0);
    drain();

    // Randomised traffic with random backpressure and idle gaps.
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      v = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUB_BYTES_INV_MODE_EN
      send(v, logic'($urandom_range(0, 1)), 1'b0);
`else
      send(v, 1'b0, 1'b0);
`endif
      guard = 0;
      while ((m_running || m_done) && guard < 300) begin
        out_ready = logic'($urandom_range(0, 1));
        tick();
        guard++;
      end
      out_ready = 1'b1;
      drain();
    end

`ifdef SUB_BYTES_INV_MODE_EN
    // Inverse substitution of the known result returns the known input.
    out_ready = 1'b1;
    send(KNOWN_RES, 1'b1, 1'b0);
    wait_out(lat);
    check_int("inv_latency", lat, BEATS);
    check128("inv_known", {w0_next, w1_next, w2_next, w3_next}, KNOWN);
    drain();
`endif

    // Other lane counts: latency and data.
    for (int k = 0; k < 4; k++) begin
      run_lane(k, KNOWN);
      run_lane(k, 128'h0);
      run_lane(k, {16{8'h53}});
      run_lane(k, {$urandom, $urandom, $urandom, $urandom});
    end
    check128("lane16_known_literal", model_sub(KNOWN, 1'b0), KNOWN_RES);

    // Scoreboard: every accepted state came out, in order.
    drain();
    tick();
    check_int("sent_vs_expected", exp_q.size(), n_sent - 1);
    check_int("results_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check128($sformatf("result_%0d", i), got_q[i], exp_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
